// File: rtl/mem_io_bridge.sv
// Purpose : routes CPU memory-port accesses to block RAM or to I/O registers (LED, switches, tick timer, TX FIFO).
// Latency : read data arrives one cycle after the address, whether it comes from RAM or I/O.
// Backpressure: the TX FIFO drains on txValid & txReady; a push into a full FIFO with no pop is dropped and flags overflow.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   outAddr, memWriteData, memWrite, memDataInbound - CPU memory port
//   ramAddr, ramWriteData, ramWe, ramReadData       - synchronous block RAM port
//   switches, leds      - board switches (asynchronous) and LED register
//   txData, txValid, txReady - byte stream toward a serial/display consumer
module mem_io_bridge #(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          TICK_DIV   = 50000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] outAddr,
  input  logic [15:0] memWriteData,
  input  logic        memWrite,
  output logic [15:0] memDataInbound,
  output logic [15:0] ramAddr,
  output logic [15:0] ramWriteData,
  output logic        ramWe,
  input  logic [15:0] ramReadData,
  input  logic [9:0]  switches,
  output logic [9:0]  leds,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam int              PRE_W         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
  localparam int              PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]      FIFO_FULL_CNT = 4'(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  logic        isIo;
  logic [15:0] ioOffset;
  logic        selLed, selSw, selTick, selTxData, selTxStat;

  assign isIo      = (outAddr >= IO_BASE);
  assign ioOffset  = outAddr - IO_BASE;
  assign selLed    = isIo && (ioOffset == 16'h0000);
  assign selSw     = isIo && (ioOffset == 16'h0001);
  assign selTick   = isIo && (ioOffset == 16'h0002);
  assign selTxData = isIo && (ioOffset == 16'h0003);
  assign selTxStat = isIo && (ioOffset == 16'h0004);

  assign ramAddr      = outAddr;
  assign ramWriteData = memWriteData;
  assign ramWe        = memWrite & ~isIo;

  // ---------------------------------------------------------------- LEDs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= '0;
    end else if (memWrite && selLed) begin
      leds <= memWriteData[9:0];
    end
  end

  // ---------------------------------------------------------------- switches
  // Two-flop synchronizer; only the second stage is ever observed.
  logic [9:0] swMeta, swSync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= switches;
      swSync <= swMeta;
    end
  end

  // ---------------------------------------------------------------- timer
  logic [PRE_W-1:0] prescaler;
  logic [15:0]      tickCount;

  // A TICK write takes priority over a coincident terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      tickCount <= '0;
    end else if (memWrite && selTick) begin
      prescaler <= '0;
      tickCount <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      tickCount <= tickCount + 16'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [3:0]       fifoCount;
  logic             overflow;
  logic             fifoEmpty, fifoFull;
  logic             pushReq, pushOk, pop;

  assign fifoEmpty = (fifoCount == 4'd0);
  assign fifoFull  = (fifoCount == FIFO_FULL_CNT);
  assign txValid   = ~fifoEmpty;
  assign pop       = txValid & txReady;
  assign pushReq   = memWrite & selTxData;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign pushOk    = pushReq & (~fifoFull | pop);
  // Gated so stale storage never leaks out while empty or in reset.
  assign txData    = txValid ? fifoMem[rdPtr] : 8'h00;

  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= memWriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   fifoCount <= fifoCount + 4'd1;
        2'b01:   fifoCount <= fifoCount - 4'd1;
        default: fifoCount <= fifoCount;
      endcase
      if (memWrite && selTxStat) begin
        overflow <= 1'b0;
      end else if (pushReq && fifoFull && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- readback
  logic [15:0] ioReadVal;

  always_comb begin
    ioReadVal = 16'h0000;
    if (selLed)         ioReadVal = {6'b0, leds};
    else if (selSw)     ioReadVal = {6'b0, swSync};
    else if (selTick)   ioReadVal = tickCount;
    else if (selTxStat) ioReadVal = {8'b0, fifoCount, 1'b0, overflow, fifoFull, fifoEmpty};
  end

  // Registering the I/O value alongside the route bit matches the RAM's
  // own one-cycle read latency, so the CPU sees a single timing.
  logic        rdIsIo;
  logic [15:0] rdIoData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdIsIo   <= 1'b0;
      rdIoData <= '0;
    end else begin
      rdIsIo   <= isIo;
      rdIoData <= ioReadVal;
    end
  end

  assign memDataInbound = rdIsIo ? rdIoData : ramReadData;

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU's memory port.
- Decodes each CPU address and routes the access either to the block RAM or to a small set of memory-mapped I/O registers:
  - LED register
  - synchronized switches
  - tick timer
  - 4-entry byte TX FIFO with a valid/ready output toward a serial/display consumer.
- Returns read data with a uniform 1-cycle latency, so RAM and I/O reads look identical to the CPU.

Parameters:
- IO_BASE, 16'hFF00, first address of the I/O window; addresses below go to RAM.
- TICK_DIV, 50000, clock cycles per timer tick.
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- outAddr  input  16  CPU address.
- memWriteData  input  16  CPU store data.
- memWrite  input  1  CPU write strobe, one cycle per store.
- memDataInbound  output  16  read data to the CPU.
- ramAddr  output  16  block RAM address, equal to outAddr.
- ramWriteData  output  16  equal to memWriteData.
- ramWe  output  1  RAM write enable.
- ramReadData  input  16  synchronous block RAM read data, 1-cycle latency.
- switches  input  10  asynchronous board switches.
- leds  output  10  LED register.
- txData  output  8  FIFO head byte.
- txValid  output  1  FIFO not empty.
- txReady  input  1  consumer accepts the head byte this cycle.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - leds=0, tick counter=0, prescaler=0
  - FIFO pointers/count=0, overflow=0
  - switch sync flops=0
  - registered read select=RAM, registered I/O read data=0
  - Resulting outputs: txValid=0, txData=0, memDataInbound=ramReadData (which selects RAM).
- Decode is combinational: isIo = (outAddr >= IO_BASE).
- ramWe = memWrite & ~isIo. Writes to the I/O window never reach the RAM.
- I/O map (offset = outAddr - IO_BASE):
  - 0x00 LED: R/W. Write loads memWriteData[9:0]. Read returns {6'b0, leds}.
  - 0x01 SW: read-only, returns {6'b0, sw_sync}. sw_sync is a 2-flop synchronizer, so a switch change is visible to reads 2 clocks later. Writes are ignored.
  - 0x02 TICK: read returns the 16-bit tick counter. Any write clears both counter and prescaler.
  - 0x03 TXDATA: write pushes memWriteData[7:0]. Read returns 0.
  - 0x04 TXSTAT: read returns {8'b0, count[3:0], 1'b0, overflow, full, empty}. Any write clears overflow.
  - Other offsets: reads return 0, writes are ignored.
- Read latency:
  - On every clock the bridge registers isIo and the I/O read value for the current outAddr.
  - In the next cycle, memDataInbound = registered isIo ? registered I/O value : ramReadData.
  - Both paths therefore have exactly 1 cycle latency.
  - Reads have no side effects.
- Timer:
  - Prescaler counts 0..TICK_DIV-1.
  - On terminal count it returns to 0 and the tick counter increments.
  - Tick counter wraps 0xFFFF -> 0x0000.
  - A TICK write in the same cycle as a terminal count: the clear wins, result is 0.
- FIFO:
  - push = memWrite & TXDATA selected; pop = txValid & txReady.
  - txData is the head entry, valid whenever count>0. Head data stays stable while txValid=1 and txReady=0.
  - Push when not full: enqueue, count+1.
  - Push when full with no pop: data dropped, overflow set sticky, count unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, overflow not set.
  - Pop when empty cannot occur, because txValid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - empty = (count==0); full = (count==FIFO_DEPTH).
- Reset asserted mid-operation discards FIFO contents immediately; txValid drops asynchronously.

Test Plan:
- Reset, then write 0x1234 to 0x0010, then read 0x0010 -> ramWe pulses once; memDataInbound=0x1234 one cycle after the address is presented; leds=0.
- Write 0x03FF to 0xFF00, then read 0xFF00 -> leds=0x3FF; read returns 0x03FF; ramWe stays 0 throughout.
- Set switches=10'h155 and read 0xFF01 at cycle +1 and at cycle +3 -> the +1 read returns the old value; the +3 read returns 0x0155.
- Run with TICK_DIV=4 for 40 cycles, read 0xFF02 (expect 0x000A); write 0xFF02, then read again -> second read returns 0x0000.
- With txReady=0, push bytes 0xA1..0xA5 to 0xFF03, then read 0xFF04 -> 5th push dropped; status = count 4, overflow=1, full=1, i.e. 0x0046. Then txReady=1 for 4 cycles -> txData sequence A1, A2, A3, A4, then txValid=0.
- FIFO full, pop and push 0xB0 in the same cycle -> count stays 4, overflow stays 0, and 0xB0 is emitted last. Then assert reset with the FIFO non-empty -> txValid=0 immediately.
